// File: rtl/pc_sequencer.sv
// pc_sequencer: word-addressed program counter with a hardware return-address
// stack, conditional branch, call/return and a pipeline stall.
// PC, stack count and sticky error flags are registered; stack_empty and
// stack_full are decoded from the registered count, so no input reaches an
// output without passing through a flop.
module pc_sequencer #(
    parameter int unsigned    N            = 16,
    parameter int unsigned    DEPTH        = 4,
    parameter logic [N-1:0]   RESET_VECTOR = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     stall,
    input  logic [2:0]               PS,
    input  logic                     cond,
    input  logic [N-1:0]             in,
    output logic [N-1:0]             PC,
    output logic [$clog2(DEPTH):0]   stack_count,
    output logic                     stack_empty,
    output logic                     stack_full,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [2:0] {
        OP_HOLD   = 3'b000,
        OP_INC    = 3'b001,
        OP_JUMP   = 3'b010,
        OP_BRANCH = 3'b011,
        OP_CALL   = 3'b100,
        OP_RET    = 3'b101,
        OP_CBR    = 3'b110,
        OP_RSVD   = 3'b111
    } op_e;

    op_e             op;
    logic [N-1:0]    pc_q, pc_d;
    logic [N-1:0]    pc1, rel;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            push;
    logic            full, empty;
    logic [PW-1:0]   wr_idx, top_idx;
    logic [N-1:0]    stack_q [DEPTH];

    assign op = op_e'(PS);

    // Sequential and relative targets; sums wrap modulo 2^N.
    assign pc1 = pc_q + N'(1);
    assign rel = pc1 + in;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));

    // When the stack is full the low PW bits of the count wrap to 0, so the
    // top index (wr_idx - 1) still lands on DEPTH-1.
    assign wr_idx  = cnt_q[PW-1:0];
    assign top_idx = wr_idx - PW'(1);

    // Next-state decode of the PS function select; stall freezes everything.
    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push  = 1'b0;
        if (!stall) begin
            case (op)
                OP_HOLD:   pc_d = pc_q;
                OP_INC:    pc_d = pc1;
                OP_JUMP:   pc_d = in;
                OP_BRANCH: pc_d = rel;
                OP_CALL: begin
                    pc_d = in;
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        push  = 1'b1;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                OP_RET: begin
                    if (empty) begin
                        pc_d  = pc1;
                        unf_d = 1'b1;
                    end else begin
                        pc_d  = stack_q[top_idx];
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                OP_CBR:    pc_d = cond ? rel : pc1;
                OP_RSVD:   pc_d = pc1;
                default:   pc_d = pc1;
            endcase
        end
    end

    // PC, stack count and sticky flags; reset beats stall and PS.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q  <= RESET_VECTOR;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Return-address storage; contents are not reset, only the count is.
    always_ff @(posedge clock) begin
        if (reset && push) begin
            stack_q[wr_idx] <= pc1;
        end
    end

    assign PC          = pc_q;
    assign stack_count = cnt_q;
    assign stack_empty = empty;
    assign stack_full  = full;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program counter with a hardware return-address stack. It generalises the processor's four-mode PC in three ways: data width is a parameter, it adds call/return and conditional-branch modes, and it adds a stall input. It sits at the head of the fetch path. It drives the instruction-memory address from the PC register and takes jump, branch and call targets from the decode stage.

## Interface
Parameters:
- N, 16, PC, target and offset width in bits (≥4)
- DEPTH, 4, return-stack entries (power of two, ≥2)
- RESET_VECTOR, 0, PC value loaded on reset (N bits)

Ports:
- clock  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-low reset; sampled on clock rising edge
- stall  input  1  1 = freeze PC and stack; PS ignored
- PS  input  3  function select (see Operation)
- cond  input  1  condition flag for PS=110
- in  input  N  absolute target (010, 100) or two's-complement word offset (011, 110)
- PC  output  N  current program counter, registered
- stack_count  output  $clog2(DEPTH)+1  valid entries on return stack
- stack_empty  output  1  stack_count == 0
- stack_full  output  1  stack_count == DEPTH
- overflow  output  1  sticky: call attempted while full
- underflow  output  1  sticky: return attempted while empty

## Operation
- Addressing is by word. PC1 = PC + 1. The relative target is REL = PC1 + in, with in treated as signed.
- All sums are taken modulo 2^N: wrap around, no saturation, no flag.
- PS decode, applied at the rising edge when reset=1 and stall=0:
  - 000 hold: PC <= PC.
  - 001 increment: PC <= PC1.
  - 010 jump: PC <= in.
  - 011 branch: PC <= REL.
  - 100 call: push PC1, then PC <= in.
  - 101 return: PC <= top of stack, then pop.
  - 110 conditional branch: PC <= cond ? REL : PC1.
  - 111 reserved: behaves exactly as 001.
- Return stack:
  - LIFO of N-bit entries held in registers, with a pointer and a count.
  - Push writes entry[count] and increments count.
  - Pop reads entry[count-1] and decrements count.
- Call while full:
  - PC <= in still happens.
  - The push is dropped and the stack contents and count are unchanged.
  - overflow is set.
- Return while empty:
  - PC <= PC1.
  - Count stays 0.
  - underflow is set.
- overflow and underflow are cleared only by reset.
- stall=1: PC, stack, count and flags all hold. PS, cond and in are don't-care.
- Reset priority is reset > stall > PS.

## Timing
- On a clock edge with reset=0:
  - PC = RESET_VECTOR, stack_count = 0, stack_empty = 1, stack_full = 0, overflow = 0, underflow = 0.
  - Stack entry contents are not reset and are unobservable.
- Reset mid-sequence:
  - Any pending call or return is discarded.
  - The stack is logically emptied in the same edge.
- Latency is one cycle. Inputs sampled at edge k show up on PC, stack_count and the flags after edge k.
- No combinational path from any input to any output. stack_empty and stack_full are decoded from the registered count.
- One operation per cycle. Back-to-back calls and returns are legal every cycle.
- A return immediately after a call returns the pushed PC1.
- Flags assert in the same cycle the offending operation takes effect.
- A return on the edge where count goes 1→0 is a legal pop; only the next return underflows.

## Test plan
- **Reset and increment:** hold reset=0 for 2 edges with RESET_VECTOR=0x0100, then release and apply PS=001 for 3 edges. Required: PC = 0x0100, 0x0101, 0x0102, 0x0103, and stack_empty=1 throughout.
- **Jump, branch and wrap:**
  - PC=0x0010, PS=010, in=0x1234 → PC=0x1234.
  - PS=011, in=0xFFFE (−2) → PC=0x1233.
  - With PC=0xFFFF, PS=001 → PC=0x0000.
  - PS=110, cond=0, in=0x0010 from PC=0x0000 → PC=0x0001.
  - Same with cond=1 → PC=0x0011.
- **Nested call/return (DEPTH=4):**
  - From PC=0x0020, call 0x0100, then 0x0200, then 0x0300. Required: stack_count reaches 3.
  - Three returns. Required: PC = 0x0201, 0x0101, 0x0021, ending with stack_empty=1 and no flags set.
- **Overflow and underflow:**
  - 5 consecutive calls with in=0x0A00..0x0A04. Required: PC=0x0A04, stack_count=4, stack_full=1, overflow=1 from the 5th edge.
  - 5 returns. Required: the first 4 pop the saved addresses in LIFO order; the 5th gives PC=pre-return PC+1 and underflow=1.
  - Both flags stay set until reset.
- **Stall:** during a call sequence, assert stall=1 for 3 cycles with PS=101. Required: PC and stack_count unchanged. After release, the next PS takes effect on the first edge.
- **Reset priority:** assert reset=0 together with stall=1 and PS=100 while stack_count=2 and overflow=1. Required: after that edge PC=RESET_VECTOR, stack_count=0, overflow=0.
